// File: rtl/move_collector.sv
`default_nettype none
// ============================================================================
//  Module      : move_collector
//  Description : Drains move lists from a column of NSQ square sources into
//                an output first-word-fall-through FIFO. Squares are served
//                one at a time, by fixed priority or round-robin. Each list
//                ends with an end-marker word (from == to). Words with the
//                invalid flag set are dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module move_collector #(
    parameter int NSQ   = 8,
    parameter int MOVW  = 19,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    input  logic [NSQ-1:0]             sq_mask,
    input  logic [NSQ-1:0]             sq_done,
    output logic [NSQ-1:0]             sq_rden,
    input  logic [NSQ*MOVW-1:0]        sq_rdata,
    output logic [MOVW-1:0]            out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [7:0]                 move_count,
    output logic                       busy,
    output logic                       done
);

    localparam int c_pw = (NSQ > 1) ? $clog2(NSQ) : 1;
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = $clog2(DEPTH + 1);
    // A read may be issued only while at least two slots are free: one for
    // the word arriving this cycle from the previous read, one for this read.
    localparam logic [c_lw-1:0] c_rd_limit = c_lw'(DEPTH - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NSQ-1:0]    flag_q, flag_d;
    logic [c_pw-1:0]   ptr_q, ptr_d;
    logic [c_pw-1:0]   last_q, last_d;
    logic              pend_q, pend_d;
    logic [7:0]        count_q, count_d;
    logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_lw-1:0]   level_q, level_d;
    logic [MOVW-1:0]   fifo_mem [DEPTH];

    logic [NSQ-1:0]    elig;
    logic              sel_found;
    logic [c_pw-1:0]   sel_idx;
    logic [MOVW-1:0]   rd_word;
    logic              arrive;
    logic              word_marker;
    logic              word_invalid;
    logic              push;
    logic              pop;

    assign elig         = sq_done & ~flag_q;
    assign rd_word      = sq_rdata[int'(ptr_q)*MOVW +: MOVW];
    assign arrive       = (state_q == READ) && pend_q;
    assign word_marker  = (rd_word[11:6] == rd_word[5:0]);
    assign word_invalid = rd_word[MOVW-1];
    assign pop          = (level_q != '0) && out_ready;

    // Pick the next square to serve: highest eligible index, or the first
    // eligible index after the last one served when round-robin is selected.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        if (!mode) begin
            for (int i = 0; i < NSQ; i++) begin
                if (elig[i]) begin
                    sel_found = 1'b1;
                    sel_idx   = c_pw'(i);
                end
            end
        end else begin
            // Walk offsets downward so the smallest offset wins last.
            for (int k = NSQ; k >= 1; k--) begin
                idx = int'(last_q) + k;
                if (idx >= NSQ) begin
                    idx = idx - NSQ;
                end
                if (elig[idx]) begin
                    sel_found = 1'b1;
                    sel_idx   = c_pw'(idx);
                end
            end
        end
    end

    // Collection state machine: next state, read strobes and FIFO push.
    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        ptr_d   = ptr_q;
        last_d  = last_q;
        count_d = count_q;
        sq_rden = '0;
        push    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    flag_d  = ~sq_mask;
                    count_d = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (&flag_q) begin
                    state_d = DONE;
                end else if (sel_found) begin
                    ptr_d   = sel_idx;
                    last_d  = sel_idx;
                    state_d = READ;
                end
            end
            READ: begin
                if (arrive && word_marker) begin
                    // End of list: anything the source returns later is
                    // never looked at because we leave READ now.
                    flag_d[ptr_q] = 1'b1;
                    state_d       = SCAN;
                end else begin
                    if (arrive && !word_invalid) begin
                        push = 1'b1;
                        if (count_q != 8'hFF) begin
                            count_d = count_q + 8'd1;
                        end
                    end
                    if (level_q <= c_rd_limit) begin
                        sq_rden[ptr_q] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        pend_d   = |sq_rden;
        wr_ptr_d = wr_ptr_q + c_aw'(push);
        rd_ptr_d = rd_ptr_q + c_aw'(pop);
        level_d  = level_q + c_lw'(push) - c_lw'(pop);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            flag_q   <= '0;
            ptr_q    <= '0;
            last_q   <= c_pw'(NSQ - 1);
            pend_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            flag_q   <= flag_d;
            ptr_q    <= ptr_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo_mem[wr_ptr_q] <= rd_word;
        end
    end

    assign out_data   = fifo_mem[rd_ptr_q];
    assign out_valid  = (level_q != '0);
    assign level      = level_q;
    assign move_count = count_q;
    assign busy       = (state_q == SCAN) || (state_q == READ);
    assign done       = (state_q == DONE) && (level_q == '0);

endmodule
`default_nettype wire
